pipe_latch_skid: RTL and testbench

Parametrised successor to the fixed EX/MEM pipeline latch. It registers NUM_WORDS data words plus FLAG_W single-bit flags between two pipeline stages. A valid/ready handshake with a 2-entry skid buffer replaces the global enable, so the upstream stage sees a registered back-pressure signal and no combinational ready path crosses the latch. It sits between any two stages of the 5-stage core: EX/MEM uses words {o, ir, b, pc_jal} and flags {jal, exception}.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_latch_skid_if.sv | 28 ++
 rtl/pipe_slot.sv | 45 ++++
 rtl/pipe_latch_skid.sv | 97 +++++++++
 tb/tb_pipe_latch_skid.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-latch definitions: NOP encoding, EX/MEM word and flag slots.
package pipe_pkg;

   // Instruction encoding written into the IR word of every bubble.
   localparam logic [31:0] NOP_IR = 32'h0000_0000;

   // EX/MEM word indices.
   localparam int unsigned WORD_O      = 0;
   localparam int unsigned WORD_IR     = 1;
   localparam int unsigned WORD_B      = 2;
   localparam int unsigned WORD_PC_JAL = 3;

   // EX/MEM flag indices.
   localparam int unsigned FLAG_JAL = 0;
   localparam int unsigned FLAG_EXC = 1;

   // Number of held entries from the two slot valid bits (skid implies main).
   function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
      return {main_valid & skid_valid, main_valid ^ skid_valid};
   endfunction

endpackage

// File: rtl/pipe_latch_skid_if.sv
// Valid/ready handshake bundle between an upstream stage, the latch and a downstream stage.
interface pipe_latch_skid_if #(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned NUM_WORDS = 4,
   parameter int unsigned FLAG_W    = 2
);
   logic                          in_valid;
   logic                          in_ready;
   logic [NUM_WORDS*WORD_W-1:0]   in_words;
   logic [FLAG_W-1:0]             in_flags;
   logic                          out_valid;
   logic                          out_ready;
   logic [NUM_WORDS*WORD_W-1:0]   out_words;
   logic [FLAG_W-1:0]             out_flags;
   logic [1:0]                    occupancy;

   // Environment side: produces input entries and consumes the head.
   modport master (
      output in_valid, in_words, in_flags, out_ready,
      input  in_ready, out_valid, out_words, out_flags, occupancy
   );

   // Latch side.
   modport slave (
      input  in_valid, in_words, in_flags, out_ready,
      output in_ready, out_valid, out_words, out_flags, occupancy
   );
endinterface

// File: rtl/pipe_slot.sv
// One latch entry: words, flags and valid, with load-enable and synchronous load-bubble.
module pipe_slot #(
   parameter int unsigned      WORD_W    = 32,
   parameter int unsigned      NUM_WORDS = 4,
   parameter int unsigned      FLAG_W    = 2,
   parameter int unsigned      IR_SLOT   = 1,
   parameter logic [WORD_W-1:0] NOP_IR   = '0
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        load,
   input  logic                        load_bubble,
   input  logic [NUM_WORDS*WORD_W-1:0] d_words,
   input  logic [FLAG_W-1:0]           d_flags,
   output logic [NUM_WORDS*WORD_W-1:0] q_words,
   output logic [FLAG_W-1:0]           q_flags,
   output logic                        q_valid
);
   localparam int unsigned BusW = NUM_WORDS * WORD_W;

   // All-zero entry except the IR word, which carries the NOP encoding.
   localparam logic [BusW-1:0] BubbleWords = BusW'(NOP_IR) << (IR_SLOT * WORD_W);

   logic [BusW-1:0]   words_q;
   logic [FLAG_W-1:0] flags_q;
   logic              valid_q;

   // Entry register; a bubble load wins over a data load.
   always_ff @(posedge clock) begin
      if (reset || load_bubble) begin
         words_q <= BubbleWords;
         flags_q <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         words_q <= d_words;
         flags_q <= d_flags;
         valid_q <= 1'b1;
      end
   end

   assign q_words = words_q;
   assign q_flags = flags_q;
   assign q_valid = valid_q;

endmodule

// File: rtl/pipe_latch_skid.sv
// Pipeline latch with a 2-entry skid buffer; upstream ready comes straight from a register.
module pipe_latch_skid #(
   parameter int unsigned       WORD_W    = 32,
   parameter int unsigned       NUM_WORDS = 4,
   parameter int unsigned       FLAG_W    = 2,
   parameter int unsigned       IR_SLOT   = pipe_pkg::WORD_IR,
   parameter logic [WORD_W-1:0] NOP_IR    = WORD_W'(pipe_pkg::NOP_IR)
) (
   input logic               clock,
   input logic               reset,
   input logic               flush,
   pipe_latch_skid_if.slave  bus
);
   import pipe_pkg::*;

   localparam int unsigned BusW = NUM_WORDS * WORD_W;

   logic [BusW-1:0]   main_words, skid_words, main_d_words;
   logic [FLAG_W-1:0] main_flags, skid_flags, main_d_flags;
   logic              main_valid, skid_valid;
   logic              accept, consume, main_free;
   logic              main_load, main_bubble, skid_load, skid_bubble;

   // Slot load decisions. Main refills from skid first so ordering is preserved.
   always_comb begin
      accept      = bus.in_valid && !skid_valid;
      consume     = main_valid && bus.out_ready;
      main_free   = consume || !main_valid;
      main_load   = 1'b0;
      main_bubble = flush;
      skid_load   = 1'b0;
      skid_bubble = flush;
      if (!flush) begin
         if (main_free) begin
            if (skid_valid) begin
               main_load   = 1'b1;
               skid_bubble = 1'b1;
            end else if (accept) begin
               main_load = 1'b1;
            end else begin
               main_bubble = 1'b1;
            end
         end else if (accept) begin
            skid_load = 1'b1;
         end
      end
   end

   // Main slot source: the skid entry when one is parked, otherwise the input.
   always_comb begin
      main_d_words = skid_valid ? skid_words : bus.in_words;
      main_d_flags = skid_valid ? skid_flags : bus.in_flags;
   end

   pipe_slot #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .FLAG_W    (FLAG_W),
      .IR_SLOT   (IR_SLOT),
      .NOP_IR    (NOP_IR)
   ) u_main (
      .clock       (clock),
      .reset       (reset),
      .load        (main_load),
      .load_bubble (main_bubble),
      .d_words     (main_d_words),
      .d_flags     (main_d_flags),
      .q_words     (main_words),
      .q_flags     (main_flags),
      .q_valid     (main_valid)
   );

   pipe_slot #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .FLAG_W    (FLAG_W),
      .IR_SLOT   (IR_SLOT),
      .NOP_IR    (NOP_IR)
   ) u_skid (
      .clock       (clock),
      .reset       (reset),
      .load        (skid_load),
      .load_bubble (skid_bubble),
      .d_words     (bus.in_words),
      .d_flags     (bus.in_flags),
      .q_words     (skid_words),
      .q_flags     (skid_flags),
      .q_valid     (skid_valid)
   );

   assign bus.in_ready  = !skid_valid;
   assign bus.out_valid = main_valid;
   assign bus.out_words = main_words;
   assign bus.out_flags = main_flags;
   assign bus.occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Directed and scoreboard bench for pipe_latch_skid.
module tb_pipe_latch_skid;
   import pipe_pkg::*;

   localparam int unsigned WW = 32;
   localparam int unsigned NW = 4;
   localparam int unsigned FW = 2;
   localparam int unsigned BW = WW * NW;

   typedef struct packed {
      logic [BW-1:0] words;
      logic [FW-1:0] flags;
   } entry_t;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   always #5 clock = ~clock;

   pipe_latch_skid_if #(.WORD_W(WW), .NUM_WORDS(NW), .FLAG_W(FW)) bus ();

   pipe_latch_skid #(
      .WORD_W    (WW),
      .NUM_WORDS (NW),
      .FLAG_W    (FW),
      .IR_SLOT   (WORD_IR),
      .NOP_IR    (NOP_IR)
   ) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;
   entry_t        q[$];
   logic [BW-1:0] bubble;
   logic [BW-1:0] ent_a, ent_b, ent_c;

   function automatic logic [BW-1:0] pack4(input logic [31:0] o, input logic [31:0] ir,
                                           input logic [31:0] b, input logic [31:0] pc);
      return {pc, b, ir, o};
   endfunction

   task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [BW-1:0] w, input logic [FW-1:0] f);
      bus.in_valid = v;
      bus.in_words = w;
      bus.in_flags = f;
   endtask

   task automatic check_state(input string tag, input logic v, input logic [1:0] occ,
                              input logic rdy, input logic [BW-1:0] w, input logic [FW-1:0] f);
      check({tag, ".out_valid"}, BW'(bus.out_valid), BW'(v));
      check({tag, ".occupancy"}, BW'(bus.occupancy), BW'(occ));
      check({tag, ".in_ready"},  BW'(bus.in_ready),  BW'(rdy));
      check({tag, ".out_words"}, bus.out_words, w);
      check({tag, ".out_flags"}, BW'(bus.out_flags), BW'(f));
   endtask

   // Advance one edge, update the reference queue from the bench's own inputs, compare.
   task automatic step_model(input string tag);
      logic   acc, con;
      entry_t e;
      acc = bus.in_valid && (q.size() < 2);
      con = (q.size() > 0) && bus.out_ready;
      e.words = bus.in_words;
      e.flags = bus.in_flags;
      tick();
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (q.size() > 0)
         check_state(tag, 1'b1, 2'(q.size()), q.size() < 2, q[0].words, q[0].flags);
      else
         check_state(tag, 1'b0, 2'd0, 1'b1, bubble, '0);
   endtask

   initial begin
      bubble        = pack4(32'h0, NOP_IR, 32'h0, 32'h0);
      ent_a         = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      ent_b         = pack4(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      ent_c         = pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3);
      reset         = 1'b1;
      flush         = 1'b0;
      bus.out_ready = 1'b0;
      drive(1'b0, '0, '0);
      tick();
      tick();
      reset = 1'b0;
      check_state("reset", 1'b0, 2'd0, 1'b1, bubble, 2'b00);

      // Streaming with out_ready high: one-cycle latency, ready never drops.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, pack4(32'h11 + i, 32'h22 + i, 32'h33 + i, 32'h44 + i), 2'b01);
         tick();
         check_state("stream", 1'b1, 2'd1, 1'b1,
                     pack4(32'h11 + i, 32'h22 + i, 32'h33 + i, 32'h44 + i), 2'b01);
      end
      drive(1'b0, '0, '0);
      tick();
      check_state("drain", 1'b0, 2'd0, 1'b1, bubble, 2'b00);

      // Back-pressure: A then B captured, C ignored while full.
      bus.out_ready = 1'b0;
      drive(1'b1, ent_a, 2'b10);
      tick();
      check_state("bp_a", 1'b1, 2'd1, 1'b1, ent_a, 2'b10);
      drive(1'b1, ent_b, 2'b01);
      tick();
      check_state("bp_b", 1'b1, 2'd2, 1'b0, ent_a, 2'b10);
      drive(1'b1, ent_c, 2'b11);
      tick();
      check_state("bp_hold", 1'b1, 2'd2, 1'b0, ent_a, 2'b10);
      drive(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      tick();
      check_state("bp_out_b", 1'b1, 2'd1, 1'b1, ent_b, 2'b01);
      tick();
      check_state("bp_empty", 1'b0, 2'd0, 1'b1, bubble, 2'b00);

      // Steady occupancy 1 with accept and consume every cycle.
      q.delete();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, FW'($urandom));
         step_model("steady");
      end
      drive(1'b0, '0, '0);
      step_model("steady_drain");

      // Flush while full, with a simultaneous input that must be dropped.
      bus.out_ready = 1'b0;
      drive(1'b1, ent_a, 2'b10);
      tick();
      drive(1'b1, ent_b, 2'b01);
      tick();
      check("fl_full.occupancy", BW'(bus.occupancy), BW'(2'd2));
      flush = 1'b1;
      drive(1'b1, ent_c, 2'b11);
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check_state("flush", 1'b0, 2'd0, 1'b1, bubble, 2'b00);
      bus.out_ready = 1'b1;
      tick();
      check_state("flush_drop", 1'b0, 2'd0, 1'b1, bubble, 2'b00);

      // Reset together with flush while data is held.
      bus.out_ready = 1'b0;
      drive(1'b1, ent_a, 2'b11);
      tick();
      drive(1'b1, ent_b, 2'b10);
      tick();
      reset = 1'b1;
      flush = 1'b1;
      drive(1'b1, ent_c, 2'b01);
      tick();
      reset = 1'b0;
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check_state("rst_flush", 1'b0, 2'd0, 1'b1, bubble, 2'b00);

      // Random handshake traffic, exception flag on some entries.
      q.delete();
      for (int i = 0; i < 300; i++) begin
         logic [FW-1:0] f;
         f[FLAG_JAL] = 1'($urandom_range(0, 1));
         f[FLAG_EXC] = ($urandom_range(0, 3) == 0);
         drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, f);
         bus.out_ready = 1'($urandom_range(0, 1));
         step_model("random");
      end
      drive(1'b0, '0, '0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step_model("random_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
